// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer read side driving 640x480@60Hz VGA with 3x3 pixel scaling
// Ports:
//   clk          50MHz system clock; a 25MHz pixel enable is derived internally
//   rst_n_async  asynchronous active-low reset
//   fb_addr      framebuffer read address (row_base + x_fb), combinational from registers
//   fb_rdata     framebuffer read data, sync RAM with 1-clk latency
//   vga_r/g/b    registered colour bits (fb pixel bits 2/1/0), forced to 0 in blanking
//   hsync_n      registered horizontal sync, active low
//   vsync_n      registered vertical sync, active low
//   vblank       registered, high while the vertical counter is past the visible area
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int FB_WIDTH  = 214,
  parameter int SCALE     = 3
) (
  input  logic        clk,
  input  logic        rst_n_async,
  output logic [15:0] fb_addr,
  input  logic [2:0]  fb_rdata,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        vblank
);
  localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]  HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [1:0]  SUB_LAST = 2'(SCALE - 1);
  localparam logic [15:0] ROW_STEP = 16'(FB_WIDTH);

  logic        phase_q, phase_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]  x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [7:0]  x_fb_q, x_fb_d;
  logic [15:0] row_base_q, row_base_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d, vblank_q, vblank_d;
  logic        h_vis, v_vis, h_wrap, v_wrap, x_wrap, y_wrap;

  always_comb begin
    h_vis      = h_cnt_q < H_VIS;
    v_vis      = v_cnt_q < V_VIS;
    h_wrap     = h_cnt_q == H_LAST;
    v_wrap     = v_cnt_q == V_LAST;
    x_wrap     = x_sub_q == SUB_LAST;
    y_wrap     = y_sub_q == SUB_LAST;
    phase_d    = ~phase_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    x_sub_d    = x_sub_q;
    x_fb_d     = x_fb_q;
    y_sub_d    = y_sub_q;
    row_base_d = row_base_q;
    rgb_d      = rgb_q;
    hsync_n_d  = hsync_n_q;
    vsync_n_d  = vsync_n_q;
    vblank_d   = vblank_q;
    if (phase_q) begin
      // output stage sees the counters before they advance, giving one pixel of latency
      rgb_d     = (h_vis && v_vis) ? fb_rdata : 3'd0;
      hsync_n_d = ~(h_cnt_q >= HS_START && h_cnt_q < HS_END);
      vsync_n_d = ~(v_cnt_q >= VS_START && v_cnt_q < VS_END);
      vblank_d  = ~v_vis;
      h_cnt_d   = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      if (h_vis) begin
        x_sub_d = x_wrap ? 2'd0 : x_sub_q + 2'd1;
        x_fb_d  = x_wrap ? x_fb_q + 8'd1 : x_fb_q;
      end
      if (h_wrap) begin
        x_sub_d = 2'd0;
        x_fb_d  = 8'd0;
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        if (v_wrap) begin
          y_sub_d    = 2'd0;
          row_base_d = 16'd0;
        end else if (v_vis) begin
          // row_base tracks (line/SCALE)*FB_WIDTH incrementally instead of multiplying
          y_sub_d    = y_wrap ? 2'd0 : y_sub_q + 2'd1;
          row_base_d = y_wrap ? row_base_q + ROW_STEP : row_base_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_async) begin
    if (!rst_n_async) begin
      phase_q    <= 1'b0;
      h_cnt_q    <= 10'd0;
      v_cnt_q    <= 10'd0;
      x_sub_q    <= 2'd0;
      x_fb_q     <= 8'd0;
      y_sub_q    <= 2'd0;
      row_base_q <= 16'd0;
      rgb_q      <= 3'd0;
      hsync_n_q  <= 1'b1;
      vsync_n_q  <= 1'b1;
      vblank_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      x_sub_q    <= x_sub_d;
      x_fb_q     <= x_fb_d;
      y_sub_q    <= y_sub_d;
      row_base_q <= row_base_d;
      rgb_q      <= rgb_d;
      hsync_n_q  <= hsync_n_d;
      vsync_n_q  <= vsync_n_d;
      vblank_q   <= vblank_d;
    end
  end

  assign fb_addr = row_base_q + {8'd0, x_fb_q};
  assign vga_r   = rgb_q[2];
  assign vga_g   = rgb_q[1];
  assign vga_b   = rgb_q[0];
  assign hsync_n = hsync_n_q;
  assign vsync_n = vsync_n_q;
  assign vblank  = vblank_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of a full-size scanout plus a shrunken-timing instance for frame-level behaviour
module tb_vga_scanout;
  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_d, addr_s;
  logic [2:0]  rdata_d = 3'd0, rdata_s = 3'd0;
  logic        r_d, g_d, b_d, hs_d, vs_d, vb_d;
  logic        r_s, g_s, b_s, hs_s, vs_s, vb_s;
  int          checks = 0, errors = 0, n = 0;
  int          bad = 0, cmp_n = 0, blank_nz = 0, fall = 0, rise = 0;
  logic [21:0] tr [2:641];
  logic [21:0] snap_s;

  vga_scanout dut (
    .clk(clk), .rst_n_async(rst_n), .fb_addr(addr_d), .fb_rdata(rdata_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .hsync_n(hs_d), .vsync_n(vs_d), .vblank(vb_d)
  );

  vga_scanout #(
    .H_VISIBLE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(9), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .FB_WIDTH(4), .SCALE(3)
  ) dut_s (
    .clk(clk), .rst_n_async(rst_n), .fb_addr(addr_s), .fb_rdata(rdata_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .hsync_n(hs_s), .vsync_n(vs_s), .vblank(vb_s)
  );

  always #10 if (clk_en) clk = ~clk;

  always @(posedge clk) begin
    rdata_d <= addr_d[2:0];
    rdata_s <= addr_s[2:0];
  end

  assign snap_s = {addr_s, r_s, g_s, b_s, hs_s, vs_s, vb_s};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int t);
    while (n < t) begin
      @(posedge clk);
      #1;
      n++;
      if (n >= 2 && n <= 641) tr[n] = snap_s;
      else if (n >= 642 && n <= 1281) begin
        cmp_n++;
        if (tr[n-640] !== snap_s) bad++;
      end
    end
  endtask

  initial begin
    clk_en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("addr_h50", 32'(addr_d), 32'd16);
    chk("addr_s_h10", 32'(addr_s), 32'd3);
    @(negedge clk) clk_en = 1'b0;
    #7 rst_n = 1'b0;
    #3;
    chk("rst_addr", 32'(addr_d), 32'd0);
    chk("rst_rgb", 32'({r_d, g_d, b_d}), 32'd0);
    chk("rst_syncs", 32'({hs_d, vs_d, vb_d}), 32'b110);
    chk("rst_s_all", 32'(snap_s), 32'b110);
    #20 rst_n = 1'b1;
    #25 n = 0;
    clk_en = 1'b1;
    goto(10);   chk("s_addr_x1", 32'(addr_s), 32'd1);
    goto(30);   chk("addr_h15", 32'(addr_d), 32'd5);
                chk("rgb_h14", 32'({r_d, g_d, b_d}), 32'b100);
    goto(32);   chk("rgb_h15", 32'({r_d, g_d, b_d}), 32'b101);
    goto(36);   chk("rgb_h17", 32'({r_d, g_d, b_d}), 32'b101);
    goto(38);   chk("rgb_h18", 32'({r_d, g_d, b_d}), 32'b110);
    goto(120);  chk("s_addr_line3", 32'(addr_s), 32'd4);
    goto(320);  chk("s_addr_last_row", 32'(addr_s), 32'd8);
    goto(342);  chk("s_addr_max", 32'(addr_s), 32'd11);
    goto(360);  chk("s_vblank_pre", 32'(vb_s), 32'd0);
    goto(362);  chk("s_vblank_on", 32'(vb_s), 32'd1);
    goto(440);  chk("s_vsync_pre", 32'(vs_s), 32'd1);
    goto(442);  chk("s_vsync_fall", 32'(vs_s), 32'd0);
    goto(520);  chk("s_vsync_hold", 32'(vs_s), 32'd0);
    goto(522);  chk("s_vsync_rise", 32'(vs_s), 32'd1);
    goto(640);  chk("s_addr_wrap", 32'(addr_s), 32'd0);
                chk("s_vblank_end_pre", 32'(vb_s), 32'd1);
    goto(642);  chk("s_vblank_off", 32'(vb_s), 32'd0);
    goto(650);  chk("s_addr_f2_x1", 32'(addr_s), 32'd1);
    goto(760);  chk("s_addr_f2_line3", 32'(addr_s), 32'd4);
    goto(1080); chk("s_vsync_f2_pre", 32'(vs_s), 32'd1);
    goto(1082); chk("s_vsync_f2_fall", 32'(vs_s), 32'd0);
    goto(1278); chk("addr_h639", 32'(addr_d), 32'd213);
    goto(1280); chk("rgb_h639", 32'({r_d, g_d, b_d}), 32'b101);
    for (int i = 1282; i <= 1601; i++) begin
      goto(i);
      if ({r_d, g_d, b_d} != 3'd0) blank_nz++;
      if (!hs_d && fall == 0) fall = n;
      if (hs_d && fall != 0 && rise == 0) rise = n;
    end
    chk("rgb_blank", 32'(blank_nz), 32'd0);
    chk("hsync_fall_clk", 32'(fall), 32'd1314);
    chk("hsync_rise_clk", 32'(rise), 32'd1506);
    goto(1606); chk("addr_line1_h3", 32'(addr_d), 32'd1);
    goto(2912); chk("hsync_l1_pre", 32'(hs_d), 32'd1);
    goto(2914); chk("hsync_l1_fall", 32'(hs_d), 32'd0);
    goto(4800); chk("addr_line3", 32'(addr_d), 32'd214);
    chk("s_trace_len", 32'(cmp_n), 32'd640);
    chk("s_trace_frame2", 32'(bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
